muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit sitting directly downstream of the register file: it consumes the two read buses (busA, busB) for MULT/MULTU/DIV/DIVU, computes over multiple cycles, and holds the 64-bit result in internal HI/LO registers. MFHI/MFLO read HI/LO back onto the writeback path, and MTHI/MTLO load them from busA. The datapath control stalls the pipeline on Busy.

## Interface
- WIDTH, 32, operand width; HI/LO are WIDTH each. Iteration count equals WIDTH.
- Clk  input  1  clock; all state changes on posedge Clk.
- Rst_n  input  1  synchronous, active-low reset, sampled on posedge Clk.
- Start  input  1  launch an operation; accepted only when Busy=0.
- Op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- busA  input  WIDTH  multiplicand or dividend, and the MTHI/MTLO data.
- busB  input  WIDTH  multiplier or divisor.
- MtHi  input  1  load HI from busA when idle.
- MtLo  input  1  load LO from busA when idle.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse when HI/LO hold a new result.
- Hi  output  WIDTH  HI register: product upper half, or remainder.
- Lo  output  WIDTH  LO register: product lower half, or quotient.

## Operation
- States: IDLE, RUN, FIX. Reset (Rst_n=0 at an edge) forces IDLE, Busy=0, Done=0, Hi=0, Lo=0, and the iteration counter to 0. Reset mid-operation abandons the operation; no partial result reaches HI/LO.
- IDLE with Start=1:
  - Latch |busA|, |busB| (signed ops), or the raw values (unsigned ops).
  - Latch the result signs: product/quotient negative iff the operand signs differ (signed ops only); remainder takes the sign of the dividend.
  - Go to RUN with counter = WIDTH.
- RUN: one iteration per cycle, counter decrements, and the state goes to FIX when the counter reaches 0.
  - Multiply: shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX:
  - Apply two's-complement negation per the latched signs.
  - Write HI/LO, pulse Done, go to IDLE.
- Divide by zero (busB=0 at Start): still runs the full latency. Result is HI=original busA (no sign fix) and LO={WIDTH{1'b1}}, for both DIV and DIVU.
- Signed overflow: DIV 32'h8000_0000 / 32'hFFFF_FFFF gives LO=32'h8000_0000, HI=0, produced naturally by the magnitude path.
- MtHi/MtLo in IDLE without Start: the register loads busA at the edge. Both may assert together.
- Simultaneous events:
  - Start and MtHi/MtLo in the same idle cycle: Start wins and the Mt write is dropped.
  - Start, MtHi or MtLo while Busy=1: ignored, with no effect on the running operation.
- Hi/Lo hold their previous values throughout RUN/FIX until the FIX edge.

## Timing
- Edge 0: Start accepted, Busy=1 from then on.
- Edges 1..WIDTH: iterations run in RUN.
- Edge WIDTH+1 (the FIX edge): HI/LO updated, Busy=0, Done=1 for exactly one cycle.
- Latency is WIDTH+1 cycles from the accept edge to the visible result (33 for WIDTH=32).
- A new Start may be accepted on the cycle in which Done=1, i.e. back-to-back operations with no gap.
- Hi/Lo are registered outputs and change only at a FIX edge, an Mt edge, or reset.

## Configuration
- MULDIV_DIV_EN defined: full divider, as specified above.
- Undefined: only the multiplier is built.
  - Start with Op[1]=1 is accepted, Busy stays 0.
  - Done pulses on the cycle after acceptance; HI/LO are unchanged.
  - MULT/MULTU are unaffected.

## Test plan
- Reset then MULTU busA=32'hFFFF_FFFF, busB=32'h0000_0002 -> Busy for 33 cycles, then Done pulse; Hi=32'h0000_0001, Lo=32'hFFFF_FFFE.
- MULT busA=32'hFFFF_FFFD (-3), busB=7 -> Hi=32'hFFFF_FFFF, Lo=32'hFFFF_FFEB (-21); Start pulsed mid-run is ignored.
- DIV busA=-7, busB=2 -> Lo=32'hFFFF_FFFD (-3), Hi=32'hFFFF_FFFF (-1). DIVU 10/3 -> Lo=3, Hi=1. Both tests only with MULDIV_DIV_EN.
- Edge divides (MULDIV_DIV_EN only):
  - DIVU 5/0 -> Hi=5, Lo=32'hFFFF_FFFF, after 33 cycles.
  - DIV 32'h8000_0000 / -1 -> Lo=32'h8000_0000, Hi=0.
- MtHi with busA=32'h1234_5678 while idle -> Hi=32'h1234_5678 next cycle. MtLo while Busy -> Lo unchanged. Start and MtLo together -> Mt dropped.
- Rst_n=0 at cycle 10 of a MULTU -> Busy=0, Done=0, Hi=Lo=0. A following DIVU 9/4 -> Lo=2, Hi=1 (with MULDIV_DIV_EN); without the macro, Done on the next cycle and Hi/Lo stay 0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
// MULT/MULTU use a shift-add multiplier; DIV/DIVU use a restoring divider.
// Both run over a sign-magnitude datapath with a final two's-complement fix.
// Optional feature macro: MULDIV_DIV_EN builds the divider. Without it, divide
// requests complete immediately with a Done pulse and HI/LO untouched.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] busA,
   input  logic [WIDTH-1:0] busB,
   input  logic             MtHi,
   input  logic             MtLo,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned ACC_W = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;     // product, or {remainder, dividend/quotient}
   logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
   logic               neg_q, neg_d;     // product/quotient needs negation
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

`ifdef MULDIV_DIV_EN
   logic               div_q, div_d;     // running operation is a divide
   logic               rneg_q, rneg_d;   // remainder needs negation
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_diff;
   logic [ACC_W-1:0]   div_step;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
`endif

   logic               accept;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [ACC_W-1:0]   mul_step;
   logic [ACC_W-1:0]   prod_fix;

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
         div_q   <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
`ifdef MULDIV_DIV_EN
         div_q   <= div_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

   // Next-state, iteration datapath and HI/LO update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      accept  = 1'b0;
`ifdef MULDIV_DIV_EN
      div_d   = div_q;
      rneg_d  = rneg_q;
`endif

      // Operand magnitudes; Op[0]=0 selects the signed variants
      a_neg = ~Op[0] & busA[WIDTH-1];
      b_neg = ~Op[0] & busB[WIDTH-1];
      a_mag = a_neg ? -busA : busA;
      b_mag = b_neg ? -busB : busB;

      // Shift-add step: conditionally add multiplicand to upper half, shift right
      mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : WIDTH'(0))};
      mul_step = {mul_sum, acc_q[WIDTH-1:1]};
      prod_fix = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
      // Restoring step: borrow out of the trial subtract means quotient bit 0
      rem_shift = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, opnd_q};
      if (rem_diff[WIDTH]) begin
         div_step = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         div_step = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
      quot_fix = neg_q  ? -acc_q[WIDTH-1:0]     : acc_q[WIDTH-1:0];
      rem_fix  = rneg_q ? -acc_q[ACC_W-1:WIDTH] : acc_q[ACC_W-1:WIDTH];
`endif

      case (state_q)
         IDLE: begin
            if (Start) begin
`ifdef MULDIV_DIV_EN
               accept = 1'b1;
`else
               accept = ~Op[1];
               done_d = Op[1];
`endif
               if (accept) begin
                  state_d = RUN;
                  cnt_d   = CNT_W'(WIDTH);
                  if (Op[1]) begin
                     acc_d  = {WIDTH'(0), a_mag};
                     opnd_d = b_mag;
                  end else begin
                     acc_d  = {WIDTH'(0), b_mag};
                     opnd_d = a_mag;
                  end
                  // Divide by zero keeps the all-ones quotient unsigned
                  neg_d = (a_neg ^ b_neg) & (~Op[1] | (busB != WIDTH'(0)));
`ifdef MULDIV_DIV_EN
                  div_d  = Op[1];
                  rneg_d = Op[1] & a_neg;
`endif
               end
            end else begin
               if (MtHi) hi_d = busA;
               if (MtLo) lo_d = busA;
            end
         end
         RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
`ifdef MULDIV_DIV_EN
            acc_d = div_q ? div_step : mul_step;
`else
            acc_d = mul_step;
`endif
            if (cnt_q == CNT_W'(1)) state_d = FIX;
         end
         FIX: begin
`ifdef MULDIV_DIV_EN
            if (div_q) begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end else begin
               hi_d = prod_fix[ACC_W-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
`else
            hi_d = prod_fix[ACC_W-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
`endif
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit with hand-computed expected values.
// Expectations for divide requests follow MULDIV_DIV_EN.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        Start = 1'b0;
   logic [1:0]  Op = 2'b00;
   logic [31:0] busA = 32'h0;
   logic [31:0] busB = 32'h0;
   logic        MtHi = 1'b0;
   logic        MtLo = 1'b0;
   logic        Busy;
   logic        Done;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int errors = 0;
   int checks = 0;
   logic [31:0] m_hi = 32'h0;   // expected HI contents
   logic [31:0] m_lo = 32'h0;   // expected LO contents

   muldiv_unit #(.WIDTH(32)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .Start (Start),
      .Op    (Op),
      .busA  (busA),
      .busB  (busB),
      .MtHi  (MtHi),
      .MtLo  (MtLo),
      .Busy  (Busy),
      .Done  (Done),
      .Hi    (Hi),
      .Lo    (Lo)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Launch one operation and follow it to completion. poke>=0 injects
   // Start/MtHi/MtLo at that run cycle; mt asserts MtLo alongside Start.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int poke, input bit mt);
      int  n;
      int  guard;
      bit  quick;
      quick = !DIV_EN && op[1];
      Op = op; busA = a; busB = b; Start = 1'b1; MtLo = mt;
      tick();
      Start = 1'b0; MtLo = 1'b0; busA = 32'h0;
      if (quick) begin
         check({tag, " quick done"}, 64'(Done), 64'd1);
         check({tag, " quick busy"}, 64'(Busy), 64'd0);
         check({tag, " quick hi"}, 64'(Hi), 64'(m_hi));
         check({tag, " quick lo"}, 64'(Lo), 64'(m_lo));
         tick();
         check({tag, " quick done drop"}, 64'(Done), 64'd0);
         return;
      end
      check({tag, " accept busy"}, 64'(Busy), 64'd1);
      check({tag, " accept done"}, 64'(Done), 64'd0);
      check({tag, " accept hold"}, {Hi, Lo}, {m_hi, m_lo});
      n = 1;
      guard = 0;
      while (!Done && guard < 100) begin
         if (guard == poke) begin
            Start = 1'b1; MtHi = 1'b1; MtLo = 1'b1; Op = 2'b01; busA = 32'hDEAD_BEEF;
         end else begin
            Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
         end
         tick();
         guard++;
         if (Busy) begin
            n++;
            check({tag, " run hold"}, {Hi, Lo}, {m_hi, m_lo});
         end
      end
      Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
      check({tag, " latency"}, 64'(n), 64'd33);
      check({tag, " done"}, 64'(Done), 64'd1);
      check({tag, " busy end"}, 64'(Busy), 64'd0);
      check({tag, " hi"}, 64'(Hi), 64'(eh));
      check({tag, " lo"}, 64'(Lo), 64'(el));
      m_hi = eh;
      m_lo = el;
   endtask

   initial begin
      tick();
      tick();
      check("reset busy", 64'(Busy), 64'd0);
      check("reset done", 64'(Done), 64'd0);
      check("reset hilo", {Hi, Lo}, 64'd0);
      Rst_n = 1'b1;
      tick();

      run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, -1, 1'b0);
      // Back-to-back start in the Done cycle, with mid-run Start/Mt pokes
      run_op("mult neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5, 1'b0);
      check("done one cycle", 64'(Done), 64'd1);
      tick();
      check("done dropped", 64'(Done), 64'd0);
      run_op("mult negneg", 2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006, -1, 1'b0);
      run_op("mult minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, -1, 1'b0);

      // MTHI / MTLO while idle
      tick();
      busA = 32'h1234_5678; MtHi = 1'b1;
      tick();
      MtHi = 1'b0;
      check("mthi hi", 64'(Hi), 64'h1234_5678);
      check("mthi lo", 64'(Lo), 64'(m_lo));
      m_hi = 32'h1234_5678;
      busA = 32'hA5A5_0F0F; MtHi = 1'b1; MtLo = 1'b1;
      tick();
      MtHi = 1'b0; MtLo = 1'b0;
      check("mt both", {Hi, Lo}, 64'hA5A5_0F0F_A5A5_0F0F);
      m_hi = 32'hA5A5_0F0F;
      m_lo = 32'hA5A5_0F0F;

      // Start with MtLo in the same cycle: the Mt write is dropped
      run_op("start+mtlo", 2'b01, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, -1, 1'b1);

      run_op("div neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, 1'b0);
      run_op("divu", 2'b11, 32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 32'h0000_0003, -1, 1'b0);
      run_op("divu by0", 2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, -1, 1'b0);
      run_op("div by0", 2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, -1, 1'b0);
      run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -1, 1'b0);

      // Reset in the middle of a MULTU
      tick();
      Op = 2'b01; busA = 32'hFFFF_FFFF; busB = 32'h0000_0003; Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      check("pre-reset busy", 64'(Busy), 64'd1);
      Rst_n = 1'b0;
      tick();
      Rst_n = 1'b1;
      check("midrst busy", 64'(Busy), 64'd0);
      check("midrst done", 64'(Done), 64'd0);
      check("midrst hilo", {Hi, Lo}, 64'd0);
      m_hi = 32'h0;
      m_lo = 32'h0;
      tick();
      check("post-rst idle", {63'd0, Busy}, 64'd0);
      run_op("divu after rst", 2'b11, 32'h0000_0009, 32'h0000_0004, 32'h0000_0001, 32'h0000_0002, -1, 1'b0);

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
